// File: rtl/traceback_reader.sv
// ---------------------------------------------------------------------------
// traceback_reader
//
// Walks the traceback path that the alignment grid left in the traceback
// memory and turns it into aligned character columns. Memory entries are
// {x, y} coordinates stored from (LENGTH-1, LENGTH-1) down to (0,0). Each
// step between consecutive entries is classified as diagonal, up or left and
// emitted as one column on a valid/ready stream, end-to-start.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   start      : one-cycle request to walk the path (ignored unless idle)
//   count      : number of valid memory entries
//   s1 / s2    : packed strings, char j at [((LENGTH-1)-j)*CWIDTH +: CWIDTH]
//                s1 is indexed by y, s2 by x
//   ren/raddr  : memory read strobe / address
//   rdata      : memory read data, valid the cycle after ren
//   out_valid  : column available
//   out_ready  : consumer accepts column
//   out_c1/c2  : column characters (0 when the matching gap flag is set)
//   out_gap1/2 : gap in s1 / s2 for this column
//   out_last   : final column, cell (0,0)
//   busy       : high whenever the walker is not idle
//   done       : one-cycle completion pulse (success or error)
//   error      : malformed path, held until the next accepted start
// ---------------------------------------------------------------------------
module traceback_reader #(
   parameter int LENGTH      = 10,
   parameter int CWIDTH      = 2,
   parameter int CORD_LENGTH = 8,
   parameter int MEM_SIZE    = 9,
   parameter int BYTE_SIZE   = 2*CORD_LENGTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [MEM_SIZE-1:0]        count,
   input  logic [LENGTH*CWIDTH-1:0]   s1,
   input  logic [LENGTH*CWIDTH-1:0]   s2,
   output logic                       ren,
   output logic [MEM_SIZE-1:0]        raddr,
   input  logic [BYTE_SIZE-1:0]       rdata,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CWIDTH-1:0]          out_c1,
   output logic [CWIDTH-1:0]          out_c2,
   output logic                       out_gap1,
   output logic                       out_gap2,
   output logic                       out_last,
   output logic                       busy,
   output logic                       done,
   output logic                       error
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      CAP,
      EMIT,
      DONE
   } state_t;

   state_t                r_state;
   logic [MEM_SIZE-1:0]   r_idx;
   logic [CORD_LENGTH-1:0] r_curX;
   logic [CORD_LENGTH-1:0] r_curY;
   logic [CORD_LENGTH-1:0] r_nxtX;
   logic [CORD_LENGTH-1:0] r_nxtY;
   logic                  r_first;
   logic                  r_final;

   logic                  r_ren;
   logic [MEM_SIZE-1:0]   r_raddr;
   logic                  r_outValid;
   logic [CWIDTH-1:0]     r_outC1;
   logic [CWIDTH-1:0]     r_outC2;
   logic                  r_outGap1;
   logic                  r_outGap2;
   logic                  r_outLast;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;

   logic [CORD_LENGTH-1:0] w_rdX;
   logic [CORD_LENGTH-1:0] w_rdY;
   logic [CORD_LENGTH-1:0] w_dx;
   logic [CORD_LENGTH-1:0] w_dy;
   logic                  w_stepLegal;
   logic                  w_rdIsCorner;
   logic                  w_rdIsOrigin;
   logic                  w_nxtIsOrigin;
   logic [MEM_SIZE-1:0]   w_idxNext;
   logic                  w_idxAtEnd;
   logic                  w_accept;
   logic [CWIDTH-1:0]     w_colC1;
   logic [CWIDTH-1:0]     w_colC2;
   logic                  w_colGap1;
   logic                  w_colGap2;
   logic [CWIDTH-1:0]     w_finalC1;
   logic [CWIDTH-1:0]     w_finalC2;

   // Character lookup by position. A decoded loop keeps every slice constant;
   // positions outside the string read as 0.
   function automatic logic [CWIDTH-1:0] charAt(
      input logic [LENGTH*CWIDTH-1:0] str,
      input logic [CORD_LENGTH-1:0]   pos
   );
      logic [CWIDTH-1:0] c;
      c = '0;
      for (int j = 0; j < LENGTH; j++) begin
         if (pos == CORD_LENGTH'(j)) begin
            c = str[(LENGTH-1-j)*CWIDTH +: CWIDTH];
         end
      end
      return c;
   endfunction

   // Memory word fields and the step from the current cell to the entry just
   // read. A step that moves "backwards" wraps to a large value and so fails
   // the legality test along with jumps of two or more.
   assign w_rdX         = rdata[BYTE_SIZE-1 -: CORD_LENGTH];
   assign w_rdY         = rdata[CORD_LENGTH-1:0];
   assign w_dx          = r_curX - w_rdX;
   assign w_dy          = r_curY - w_rdY;
   assign w_stepLegal   = (w_dx <= CORD_LENGTH'(1)) && (w_dy <= CORD_LENGTH'(1)) &&
                          !((w_dx == '0) && (w_dy == '0));
   assign w_rdIsCorner  = (w_rdX == CORD_LENGTH'(LENGTH-1)) && (w_rdY == CORD_LENGTH'(LENGTH-1));
   assign w_rdIsOrigin  = (w_rdX == '0) && (w_rdY == '0);
   assign w_nxtIsOrigin = (r_nxtX == '0) && (r_nxtY == '0);
   assign w_idxNext     = r_idx + MEM_SIZE'(1);
   assign w_idxAtEnd    = ({1'b0, r_idx} + (MEM_SIZE+1)'(1)) >= {1'b0, count};
   assign w_accept      = r_outValid & out_ready;
   assign w_finalC1     = charAt(s1, '0);
   assign w_finalC2     = charAt(s2, '0);

   // Column content for a legal step out of the current cell. Only y moving
   // means an "up" step (gap in s2); only x moving means "left" (gap in s1);
   // both moving is a diagonal pair.
   always_comb begin
      w_colC1   = charAt(s1, r_curY);
      w_colC2   = charAt(s2, r_curX);
      w_colGap1 = 1'b0;
      w_colGap2 = 1'b0;
      if (w_dx == '0) begin
         w_colGap2 = 1'b1;
         w_colC2   = '0;
      end else if (w_dy == '0) begin
         w_colGap1 = 1'b1;
         w_colC1   = '0;
      end
   end

   // Walker FSM. Every output is a register updated on the transition into
   // the state that owns it, so nothing reaches the ports combinationally
   // from out_ready or rdata. done is a pulse: it defaults low every cycle
   // and is raised only on entry to DONE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_idx      <= '0;
         r_curX     <= '0;
         r_curY     <= '0;
         r_nxtX     <= '0;
         r_nxtY     <= '0;
         r_first    <= 1'b0;
         r_final    <= 1'b0;
         r_ren      <= 1'b0;
         r_raddr    <= '0;
         r_outValid <= 1'b0;
         r_outC1    <= '0;
         r_outC2    <= '0;
         r_outGap1  <= 1'b0;
         r_outGap2  <= 1'b0;
         r_outLast  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_idx   <= '0;
                  r_first <= 1'b1;
                  r_final <= 1'b0;
                  r_error <= 1'b0;
                  r_busy  <= 1'b1;
                  r_raddr <= '0;
                  // An empty path issues no read; REQ sees ren low and
                  // turns that into the error exit.
                  r_ren   <= (count != '0);
                  r_state <= REQ;
               end
            end

            REQ: begin
               r_ren <= 1'b0;
               if (!r_ren) begin
                  r_error <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end else begin
                  r_state <= CAP;
               end
            end

            CAP: begin
               if (r_first) begin
                  r_first <= 1'b0;
                  r_curX  <= w_rdX;
                  r_curY  <= w_rdY;
                  if (!w_rdIsCorner) begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else if (w_rdIsOrigin) begin
                     // Single-cell grid: the corner is already the origin.
                     r_final    <= 1'b1;
                     r_outValid <= 1'b1;
                     r_outC1    <= w_finalC1;
                     r_outC2    <= w_finalC2;
                     r_outGap1  <= 1'b0;
                     r_outGap2  <= 1'b0;
                     r_outLast  <= 1'b1;
                     r_state    <= EMIT;
                  end else if (w_idxAtEnd) begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_idx   <= w_idxNext;
                     r_raddr <= w_idxNext;
                     r_ren   <= 1'b1;
                     r_state <= REQ;
                  end
               end else begin
                  r_nxtX <= w_rdX;
                  r_nxtY <= w_rdY;
                  if (w_stepLegal) begin
                     r_outValid <= 1'b1;
                     r_outC1    <= w_colC1;
                     r_outC2    <= w_colC2;
                     r_outGap1  <= w_colGap1;
                     r_outGap2  <= w_colGap2;
                     r_outLast  <= 1'b0;
                     r_state    <= EMIT;
                  end else begin
                     r_error <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end
               end
            end

            EMIT: begin
               if (w_accept) begin
                  r_outValid <= 1'b0;
                  r_outLast  <= 1'b0;
                  if (r_final) begin
                     r_done  <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_curX <= r_nxtX;
                     r_curY <= r_nxtY;
                     if (w_nxtIsOrigin) begin
                        // Reaching (0,0) needs no further read: its column
                        // is emitted straight away as the last one.
                        r_final    <= 1'b1;
                        r_outValid <= 1'b1;
                        r_outC1    <= w_finalC1;
                        r_outC2    <= w_finalC2;
                        r_outGap1  <= 1'b0;
                        r_outGap2  <= 1'b0;
                        r_outLast  <= 1'b1;
                     end else if (w_idxAtEnd) begin
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                     end else begin
                        r_idx   <= w_idxNext;
                        r_raddr <= w_idxNext;
                        r_ren   <= 1'b1;
                        r_state <= REQ;
                     end
                  end
               end
            end

            DONE: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign ren       = r_ren;
   assign raddr     = r_raddr;
   assign out_valid = r_outValid;
   assign out_c1    = r_outC1;
   assign out_c2    = r_outC2;
   assign out_gap1  = r_outGap1;
   assign out_gap2  = r_outGap2;
   assign out_last  = r_outLast;
   assign busy      = r_busy;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_traceback_reader.sv
// ---------------------------------------------------------------------------
// tb_traceback_reader
//
// Table-driven bench for traceback_reader with LENGTH=4. Each vector holds
// the strings, memory image, count, optional stall/restart stimulus and the
// expected columns, handshake cycles, done cycle and error flag. Cycle 0 is
// the edge that samples start; cycle k is observed on the falling edge
// before rising edge k.
// ---------------------------------------------------------------------------
module tb_traceback_reader;

   localparam int LENGTH      = 4;
   localparam int CWIDTH      = 2;
   localparam int CORD_LENGTH = 8;
   localparam int MEM_SIZE    = 9;
   localparam int BYTE_SIZE   = 16;
   localparam int NVEC        = 8;

   typedef struct packed {
      logic [7:0]        s1v;
      logic [7:0]        s2v;
      logic [8:0]        cnt;
      logic [7:0][15:0]  mem;
      logic [7:0]        stall;
      logic [7:0]        startAgain;
      logic [7:0]        nCols;
      logic [5:0][5:0]   cols;
      logic [5:0][7:0]   hs;
      logic [7:0]        doneCyc;
      logic              err;
      logic              lst;
   } vec_t;

   logic                 clk;
   logic                 reset;
   logic                 start;
   logic [MEM_SIZE-1:0]  count;
   logic [7:0]           s1;
   logic [7:0]           s2;
   logic                 ren;
   logic [MEM_SIZE-1:0]  raddr;
   logic [BYTE_SIZE-1:0] rdata;
   logic                 outValid;
   logic                 outReady;
   logic [1:0]           outC1;
   logic [1:0]           outC2;
   logic                 outGap1;
   logic                 outGap2;
   logic                 outLast;
   logic                 busy;
   logic                 done;
   logic                 error;

   logic [15:0]          mem [16];
   vec_t                 vecs [NVEC];
   vec_t                 t;
   int                   checks;
   int                   errors;

   traceback_reader #(
      .LENGTH      (LENGTH),
      .CWIDTH      (CWIDTH),
      .CORD_LENGTH (CORD_LENGTH),
      .MEM_SIZE    (MEM_SIZE),
      .BYTE_SIZE   (BYTE_SIZE)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .count     (count),
      .s1        (s1),
      .s2        (s2),
      .ren       (ren),
      .raddr     (raddr),
      .rdata     (rdata),
      .out_valid (outValid),
      .out_ready (outReady),
      .out_c1    (outC1),
      .out_c2    (outC2),
      .out_gap1  (outGap1),
      .out_gap2  (outGap2),
      .out_last  (outLast),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Traceback memory model: read data appears the cycle after ren.
   always @(posedge clk) begin
      if (ren) rdata <= mem[raddr[3:0]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t baseVec();
      vec_t b;
      b = '0;
      b.mem = {8{16'hFFFF}};
      b.s1v = 8'b00_01_10_11;
      b.s2v = 8'b00_01_10_11;
      return b;
   endfunction

   task automatic loadVec(input vec_t tv);
      s1    = tv.s1v;
      s2    = tv.s2v;
      count = tv.cnt;
      for (int i = 0; i < 16; i++) mem[i] = (i < 8) ? tv.mem[i] : 16'hFFFF;
   endtask

   // Runs one vector from start to its done pulse and compares everything
   // it observed against the vector's expectations.
   task automatic applyStimulus(input int v);
      vec_t       tv;
      logic [5:0] colGot [8];
      int         hsGot [8];
      logic       lastGot [8];
      int         nCols;
      int         doneCyc;
      logic       errAtDone;
      logic       busyAt1;
      logic       prevStall;
      logic [6:0] held;
      logic [6:0] cur;
      tv        = vecs[v];
      loadVec(tv);
      nCols     = 0;
      doneCyc   = -1;
      errAtDone = 1'b0;
      busyAt1   = 1'b0;
      prevStall = 1'b0;
      held      = '0;
      @(negedge clk);
      start    = 1'b1;
      outReady = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 60 && doneCyc < 0; k++) begin
         @(negedge clk);
         start    = (k == int'(tv.startAgain)) ? 1'b1 : 1'b0;
         outReady = (k >= 5 && k < 5 + int'(tv.stall)) ? 1'b0 : 1'b1;
         cur = {outGap1, outGap2, outC1, outC2, outLast};
         if (k == 1) busyAt1 = busy;
         if (prevStall) begin
            checkOutput($sformatf("v%0d valid held c%0d", v, k), 32'(outValid), 32'd1);
            checkOutput($sformatf("v%0d data held c%0d", v, k), 32'(cur), 32'(held));
         end
         prevStall = 1'b0;
         if (outValid && !outReady) begin
            prevStall = 1'b1;
            held      = cur;
         end
         if (outValid && outReady) begin
            if (nCols < 8) begin
               colGot[nCols]  = cur[6:1];
               hsGot[nCols]   = k;
               lastGot[nCols] = outLast;
            end
            nCols++;
         end
         if (done) begin
            doneCyc   = k;
            errAtDone = error;
         end
         @(posedge clk);
      end
      start = 1'b0;
      if (doneCyc < 0) checkOutput($sformatf("v%0d done timeout", v), 32'd0, 32'd1);
      checkOutput($sformatf("v%0d busy at cycle 1", v), 32'(busyAt1), 32'd1);
      checkOutput($sformatf("v%0d done cycle", v), 32'(doneCyc), 32'(tv.doneCyc));
      checkOutput($sformatf("v%0d error at done", v), 32'(errAtDone), 32'(tv.err));
      checkOutput($sformatf("v%0d column count", v), 32'(nCols), 32'(tv.nCols));
      for (int c = 0; c < int'(tv.nCols) && c < nCols && c < 6; c++) begin
         checkOutput($sformatf("v%0d col%0d data", v, c), 32'(colGot[c]), 32'(tv.cols[c]));
         checkOutput($sformatf("v%0d col%0d cycle", v, c), 32'(hsGot[c]), 32'(tv.hs[c]));
         checkOutput($sformatf("v%0d col%0d last", v, c), 32'(lastGot[c]),
                     32'(tv.lst && (c == int'(tv.nCols) - 1)));
      end
      @(negedge clk);
      checkOutput($sformatf("v%0d idle after done", v), {28'd0, busy, done, outValid, error},
                  {31'd0, tv.err});
   endtask

   // Reset lands in the middle of the second column: outputs must clear
   // before the next clock and no done pulse may follow.
   task automatic midWalkReset();
      loadVec(vecs[0]);
      @(negedge clk);
      start    = 1'b1;
      outReady = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) begin
         @(posedge clk);
         @(negedge clk);
      end
      checkOutput("midreset valid before reset", 32'(outValid), 32'd1);
      #1 reset = 1'b0;
      #1 checkOutput("midreset outputs cleared",
                     32'({ren, raddr, outValid, outC1, outC2, outGap1, outGap2, outLast, busy, done, error}),
                     32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("midreset no done", 32'({done, busy, outValid}), 32'd0);
      reset = 1'b1;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      count    = '0;
      s1       = '0;
      s2       = '0;
      outReady = 1'b1;
      for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;

      // v0: straight diagonal path
      t = baseVec();
      t.cnt = 9'd4;
      t.mem[0] = 16'h0303; t.mem[1] = 16'h0202; t.mem[2] = 16'h0101; t.mem[3] = 16'h0000;
      t.nCols = 8'd4;
      t.cols[0] = 6'b001111; t.cols[1] = 6'b001010; t.cols[2] = 6'b000101; t.cols[3] = 6'b000000;
      t.hs[0] = 8'd5; t.hs[1] = 8'd8; t.hs[2] = 8'd11; t.hs[3] = 8'd12;
      t.doneCyc = 8'd13; t.err = 1'b0; t.lst = 1'b1;
      vecs[0] = t;

      // v1: left, diagonal, up, diagonal, final; extra start while busy
      t = baseVec();
      t.cnt = 9'd5;
      t.mem[0] = 16'h0303; t.mem[1] = 16'h0203; t.mem[2] = 16'h0102; t.mem[3] = 16'h0101;
      t.mem[4] = 16'h0000;
      t.startAgain = 8'd6;
      t.nCols = 8'd5;
      t.cols[0] = 6'b100011; t.cols[1] = 6'b001110; t.cols[2] = 6'b011000;
      t.cols[3] = 6'b000101; t.cols[4] = 6'b000000;
      t.hs[0] = 8'd5; t.hs[1] = 8'd8; t.hs[2] = 8'd11; t.hs[3] = 8'd14; t.hs[4] = 8'd15;
      t.doneCyc = 8'd16; t.err = 1'b0; t.lst = 1'b1;
      vecs[1] = t;

      // v2: v0 with consumer stalled for 5 cycles at the first column
      t = vecs[0];
      t.stall = 8'd5;
      t.hs[0] = 8'd10; t.hs[1] = 8'd13; t.hs[2] = 8'd16; t.hs[3] = 8'd17;
      t.doneCyc = 8'd18;
      vecs[2] = t;

      // v3: illegal jump (3,3) -> (1,1)
      t = baseVec();
      t.cnt = 9'd2;
      t.mem[0] = 16'h0303; t.mem[1] = 16'h0101;
      t.doneCyc = 8'd5; t.err = 1'b1;
      vecs[3] = t;

      // v4: first entry is not the corner
      t = baseVec();
      t.cnt = 9'd4;
      t.mem[0] = 16'h0203; t.mem[1] = 16'h0202; t.mem[2] = 16'h0101; t.mem[3] = 16'h0000;
      t.doneCyc = 8'd3; t.err = 1'b1;
      vecs[4] = t;

      // v5: path truncated by count before reaching the origin
      t = baseVec();
      t.cnt = 9'd3;
      t.mem[0] = 16'h0303; t.mem[1] = 16'h0202; t.mem[2] = 16'h0101;
      t.nCols = 8'd2;
      t.cols[0] = 6'b001111; t.cols[1] = 6'b001010;
      t.hs[0] = 8'd5; t.hs[1] = 8'd8;
      t.doneCyc = 8'd9; t.err = 1'b1; t.lst = 1'b0;
      vecs[5] = t;

      // v6: empty path
      t = baseVec();
      t.cnt = 9'd0;
      t.doneCyc = 8'd2; t.err = 1'b1;
      vecs[6] = t;

      // v7: v1 path with distinct strings so s1/s2 and x/y mix-ups show
      t = vecs[1];
      t.startAgain = 8'd0;
      t.s2v = 8'b11_10_01_00;
      t.cols[0] = 6'b100000; t.cols[1] = 6'b001101; t.cols[2] = 6'b011000;
      t.cols[3] = 6'b000110; t.cols[4] = 6'b000011;
      vecs[7] = t;

      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset outputs",
                  32'({ren, raddr, outValid, outC1, outC2, outGap1, outGap2, outLast, busy, done, error}),
                  32'd0);
      reset = 1'b1;

      for (int v = 0; v < NVEC; v++) applyStimulus(v);

      midWalkReset();
      applyStimulus(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/traceback_reader.md
# traceback_reader

Reads the traceback path that the alignment grid writes into the traceback memory and turns it into aligned character columns. Memory entries are `{x, y}` coordinates, stored from (LENGTH-1, LENGTH-1) down to (0,0). The block walks these entries in order and classifies each step as diagonal, up or left. Each resulting column, either a character pair or a gap, goes out over a valid/ready stream to the downstream alignment printer/UART packer.

## Interface
- LENGTH, 10, characters per input string
- CWIDTH, 2, bits per character
- CORD_LENGTH, 8, bits per coordinate
- MEM_SIZE, 9, memory address width
- BYTE_SIZE, 2*CORD_LENGTH, memory word width; word = {x[CORD_LENGTH-1:0], y[CORD_LENGTH-1:0]}, x in upper half
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
- start  in  1  one-cycle request to walk the path; ignored unless idle
- count  in  MEM_SIZE  number of valid memory entries (final write address + 1)
- s1  in  LENGTH*CWIDTH  string 1, char j at bits [((LENGTH-1)-j)*CWIDTH +: CWIDTH], indexed by y
- s2  in  LENGTH*CWIDTH  string 2, same packing, indexed by x
- ren  out  1  memory read strobe
- raddr  out  MEM_SIZE  memory read address
- rdata  in  BYTE_SIZE  memory read data, valid in the cycle after ren
- out_valid  out  1  column available
- out_ready  in  1  consumer accepts column
- out_c1 / out_c2  out  CWIDTH each  column characters; 0 when the matching gap flag is set
- out_gap1 / out_gap2  out  1 each  gap in s1 / s2 for this column
- out_last  out  1  final column (cell (0,0))
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at completion (success or error)
- error  out  1  malformed path; held until next accepted start

## Operation
- States: IDLE, REQ, CAP, EMIT, DONE.
- Registers: idx (MEM_SIZE), cur and nxt coordinates, first flag, final flag.
- IDLE:
  - start=1 → idx=0, first=1, final=0, error=0 → REQ.
  - count==0 at start → error=1 → DONE.
- REQ: ren=1, raddr=idx → CAP.
- CAP, first=1: cur←rdata, first←0.
  - rdata != (LENGTH-1, LENGTH-1) → error.
  - rdata == (0,0) → final=1 → EMIT.
  - idx+1 ≥ count → error.
  - otherwise idx++ → REQ.
- CAP, first=0: nxt←rdata. Legal steps: dx∈{0,1}, dy∈{0,1}, not both 0. Legal → EMIT; otherwise error.
- EMIT column content from cur (x,y) and step to nxt:
  - Diagonal: (s1[y], s2[x]), no gap.
  - Up (dy=1, dx=0): (s1[y], gap2).
  - Left (dx=1, dy=0): (gap1, s2[x]).
  - final=1: (s1[0], s2[0]), out_last=1.
- EMIT handshake (out_valid & out_ready), in priority order:
  - final → DONE.
  - else cur←nxt; nxt==(0,0) → final=1, stay EMIT.
  - else idx+1 ≥ count → error.
  - else idx++ → REQ.
- Column order is end-to-start; the consumer reverses it.
- DONE: done=1 for one cycle → IDLE.
- Any error → error=1, out_valid=0 → DONE.

## Timing
- Reset values: state IDLE; ren, raddr, out_valid, out_c1, out_c2, out_gap1, out_gap2, out_last, busy, done, error all 0.
- All outputs decode from registers only. No combinational path from out_ready or rdata to outputs.
- out_valid stays high and out_* stay stable until the handshake completes; out_valid never drops without one.
- Cycle 0 is the edge that samples start. Then REQ@1, CAP@2. Each non-final column takes REQ, CAP, EMIT (3 cycles minimum). The final column adds one EMIT cycle, DONE adds one.
- Stall: each cycle of out_ready=0 in EMIT adds exactly one cycle.
- start while busy: no effect.
- Reset asserted mid-walk: immediate return to IDLE, outputs cleared, no done pulse.

## Test plan
- LENGTH=4, s1=s2=8'b00_01_10_11, memory (3,3),(2,2),(1,1),(0,0), count=4, out_ready=1 → 4 diagonal columns (11,11),(10,10),(01,01),(00,00). out_valid in cycles 5, 8, 11, 12; out_last only in cycle 12; done in cycle 13; error=0.
- Memory (3,3),(2,3),(1,2),(1,1),(0,0) → columns: left (gap1, s2[3]); diagonal (s1[3], s2[2]); up (s1[2], gap2); diagonal (s1[1], s2[1]); final (s1[0], s2[0]) with last.
- Same as scenario 1 with out_ready low for 5 cycles at the first EMIT → out_valid and data held stable; done at cycle 18.
- Memory (3,3),(1,1) → error=1, no out_valid, done pulse. First entry (2,3) → error after first CAP.
- count=3 with (3,3),(2,2),(1,1) → 2 columns emitted, then error=1 with no out_last. count=0 → error and done at cycle 2.
- reset driven low during the second EMIT → all outputs 0 immediately. After release, a new start replays the full sequence correctly.
